mux_4to1: RTL and testbench

Registered 4-to-1 multiplexer that routes one of four equal-width data lanes to a single output, selected by a 2-bit select. It is a leaf datapath element used wherever a small, timing-clean source-select stage is needed. Output and a valid flag are registered, giving a fixed one-cycle latency. With WIDTH=1 the block is a registered single-bit 4:1 mux with Y = I[S].

---
 rtl/mux_4to1.sv | 56 +++++
 tb/tb_mux_4to1.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mux_4to1.sv
// mux_4to1: registered 4-to-1 lane select with a one-cycle latency.
//
// Handshake: in_valid qualifies I and S on the rising edge of clk. A sample
// is accepted on every edge where in_valid is high, because there is no
// ready and no backpressure. Exactly one clock later, out_valid is high for
// one cycle and Y holds the selected lane. When in_valid is low, Y keeps its
// last captured value and out_valid drops.
module mux_4to1 #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [4*WIDTH-1:0] I,
  input  logic [1:0]         S,
  input  logic               in_valid,
  output logic [WIDTH-1:0]   Y,
  output logic               out_valid
);

  logic [WIDTH-1:0] w_lane;
  logic [WIDTH-1:0] r_y;
  logic             r_valid;

  // Extract the lane addressed by S. Every S code is legal, and each one maps to an exact slice.
  always_comb begin
    w_lane = '0;
    case (S)
      2'b00: w_lane = I[0*WIDTH +: WIDTH];
      2'b01: w_lane = I[1*WIDTH +: WIDTH];
      2'b10: w_lane = I[2*WIDTH +: WIDTH];
      2'b11: w_lane = I[3*WIDTH +: WIDTH];
    endcase
  end

  // Capture the selected lane on a valid cycle and hold it otherwise. Reset clears the output asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y <= '0;
    end else if (in_valid) begin
      r_y <= w_lane;
    end
  end

  // Register the valid flag, so it is high only for the cycle after an accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
    end
  end

  assign Y         = r_y;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_mux_4to1.sv
// tb_mux_4to1: directed checks of the registered 4:1 mux at WIDTH=1 and WIDTH=8.
module tb_mux_4to1;

  logic        clk;
  logic        rst_n;

  logic [3:0]  i1;
  logic [1:0]  s1;
  logic        v1;
  logic        y1;
  logic        ov1;

  logic [31:0] i8;
  logic [1:0]  s8;
  logic        v8;
  logic [7:0]  y8;
  logic        ov8;

  int n_tests;
  int n_fail;

  logic [7:0] exp_q[$];

  mux_4to1 #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .I         (i1),
    .S         (s1),
    .in_valid  (v1),
    .Y         (y1),
    .out_valid (ov1)
  );

  mux_4to1 #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .I         (i8),
    .S         (s8),
    .in_valid  (v8),
    .Y         (y8),
    .out_valid (ov8)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Checking
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drivers: apply inputs on the falling edge, then sample 1 time unit after the next rising edge.
  task automatic step1(input logic [3:0] i, input logic [1:0] s, input logic v);
    @(negedge clk);
    i1 = i;
    s1 = s;
    v1 = v;
    @(posedge clk);
    #1;
  endtask

  task automatic step8(input logic [31:0] i, input logic [1:0] s, input logic v);
    @(negedge clk);
    i8 = i;
    s8 = s;
    v8 = v;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop the next hand-computed expectation and compare it with y1.
  task automatic check_y1(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: expected queue empty", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, {7'b0, y1}, e);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // Reset held low with active inputs: the outputs must stay cleared across edges.
    rst_n = 1'b0;
    i1 = 4'b1111; s1 = 2'd3; v1 = 1'b1;
    i8 = 32'hFFFF_FFFF; s8 = 2'd3; v8 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("rst_y1",   {7'b0, y1}, 8'h00);
      check("rst_ov1",  {7'b0, ov1}, 8'h00);
      check("rst_y8",   y8, 8'h00);
      check("rst_ov8",  {7'b0, ov8}, 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    v1 = 1'b0;
    v8 = 1'b0;

    // Select sweep with I=1010: expect Y=0,1,0,1.
    exp_q.push_back(8'd0); exp_q.push_back(8'd1);
    exp_q.push_back(8'd0); exp_q.push_back(8'd1);
    for (int k = 0; k < 4; k++) begin
      step1(4'b1010, 2'(k), 1'b1);
      check_y1($sformatf("sel_1010_s%0d", k));
      check($sformatf("sel_ov_s%0d", k), {7'b0, ov1}, 8'h01);
    end

    // Complement sweep with I=0101: expect Y=1,0,1,0.
    exp_q.push_back(8'd1); exp_q.push_back(8'd0);
    exp_q.push_back(8'd1); exp_q.push_back(8'd0);
    for (int k = 0; k < 4; k++) begin
      step1(4'b0101, 2'(k), 1'b1);
      check_y1($sformatf("sel_0101_s%0d", k));
    end

    // Edge lanes: the only set bit is in lane 0, then in lane 3.
    exp_q.push_back(8'd1);
    step1(4'b0001, 2'd0, 1'b1);
    check_y1("lane0_only");
    exp_q.push_back(8'd1);
    step1(4'b1000, 2'd3, 1'b1);
    check_y1("lane3_only");

    // Hold: capture a 1, then three idle cycles with different inputs.
    step1(4'b1010, 2'd1, 1'b1);
    check("hold_cap_y", {7'b0, y1}, 8'h01);
    check("hold_cap_ov", {7'b0, ov1}, 8'h01);
    for (int k = 0; k < 3; k++) begin
      step1(4'b0000, 2'd0, 1'b0);
      check($sformatf("hold_y_%0d", k), {7'b0, y1}, 8'h01);
      check($sformatf("hold_ov_%0d", k), {7'b0, ov1}, 8'h00);
    end

    // Async reset between edges: the outputs clear before the next rising edge.
    step1(4'b1010, 2'd3, 1'b1);
    check("pre_async_y", {7'b0, y1}, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_y", {7'b0, y1}, 8'h00);
    check("async_ov", {7'b0, ov1}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    v1 = 1'b0;

    // Wide lanes: expect A1, B2, C3, D4.
    step8({8'hD4, 8'hC3, 8'hB2, 8'hA1}, 2'd0, 1'b1);
    check("w8_s0", y8, 8'hA1);
    check("w8_ov", {7'b0, ov8}, 8'h01);
    step8({8'hD4, 8'hC3, 8'hB2, 8'hA1}, 2'd1, 1'b1);
    check("w8_s1", y8, 8'hB2);
    step8({8'hD4, 8'hC3, 8'hB2, 8'hA1}, 2'd2, 1'b1);
    check("w8_s2", y8, 8'hC3);
    step8({8'hD4, 8'hC3, 8'hB2, 8'hA1}, 2'd3, 1'b1);
    check("w8_s3", y8, 8'hD4);
    step8(32'h0000_0000, 2'd0, 1'b0);
    check("w8_hold_y", y8, 8'hD4);
    check("w8_hold_ov", {7'b0, ov8}, 8'h00);

    // Mid-stream reset just after the S=1 capture.
    step1(4'b1010, 2'd0, 1'b1);
    check("mid_s0", {7'b0, y1}, 8'h00);
    step1(4'b1010, 2'd1, 1'b1);
    check("mid_s1", {7'b0, y1}, 8'h01);
    rst_n = 1'b0;
    #1;
    check("mid_rst_y", {7'b0, y1}, 8'h00);
    check("mid_rst_ov", {7'b0, ov1}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    i1 = 4'b1010;
    s1 = 2'd3;
    v1 = 1'b1;
    @(posedge clk);
    #1;
    check("mid_after_y", {7'b0, y1}, 8'h01);
    check("mid_after_ov", {7'b0, ov1}, 8'h01);

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
